// File: rtl/nes_bus_pkg.sv
// Shared CPU bus definitions: address map, loader FSM encoding, common opcodes.
package nes_bus_pkg;

  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] RAM_END  = 16'h1FFF;
  localparam logic [15:0] PRG_BASE = 16'h8000;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } load_state_e;

  // Source feeding Data_bus after an edge.
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_ROM  = 2'd2
  } bus_src_e;

  localparam logic [7:0] ADC_IMM = 8'h69;
  localparam logic [7:0] SBC_IMM = 8'he9;
  localparam logic [7:0] SEC     = 8'h38;
  localparam logic [7:0] CLC     = 8'h18;
  localparam logic [7:0] LDA_IMM = 8'ha9;
  localparam logic [7:0] JMP_ABS = 8'h4c;
  localparam logic [7:0] NOP     = 8'hea;

  // $0000-$1FFF: internal RAM window (mirrored).
  function automatic logic is_ram(input logic [15:0] a);
    return (a & ~RAM_END) == RAM_BASE;
  endfunction

  // $8000-$FFFF: PRG ROM window.
  function automatic logic is_prg(input logic [15:0] a);
    return a[15] == PRG_BASE[15];
  endfunction

endpackage

// File: rtl/sync_ram_1rw.sv
// Single-port synchronous RAM with write enable and registered read.
module sync_ram_1rw #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write on enable; read register always samples the addressed word (old data on write).
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the CPU bus: mirrored 2 KB RAM, streamed-in PRG ROM,
// open-bus emulation, and a loader FSM that holds the CPU in reset while loading.
module cpu_bus_responder
  import nes_bus_pkg::*;
#(
  parameter int unsigned RAM_AW   = 11,
  parameter int unsigned PRG_AW   = 15,
  parameter bit          OPEN_BUS = 1'b1
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] Addr_bus,
  input  logic        rw,
  input  logic [7:0]  Data_wr,
  output logic [7:0]  Data_bus,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        ld_reload,
  output logic        cpu_hold
);

  localparam logic [PRG_AW-1:0] PTR_MAX = '1;

  load_state_e        state_q, state_d;
  logic [PRG_AW-1:0]  ptr_q, ptr_d, wr_ptr;
  bus_src_e           src_q, src_d;
  logic [7:0]         hold_q, hold_d;
  logic [7:0]         latch_q, latch_d;
  logic               run, ram_hit, prg_hit, ram_we, rom_we;
  logic [PRG_AW-1:0]  rom_addr;
  logic [7:0]         ram_rdata, rom_rdata;

  assign run      = (state_q == RUN);
  assign ram_hit  = is_ram(Addr_bus);
  assign prg_hit  = is_prg(Addr_bus);
  assign ram_we   = run && !rw && ram_hit;
  assign rom_addr = run ? Addr_bus[PRG_AW-1:0] : wr_ptr;

  sync_ram_1rw #(.AW(RAM_AW), .DW(8)) u_ram (
    .clk_i   (clk_ph1),
    .we_i    (ram_we),
    .addr_i  (Addr_bus[RAM_AW-1:0]),
    .wdata_i (Data_wr),
    .rdata_o (ram_rdata)
  );

  sync_ram_1rw #(.AW(PRG_AW), .DW(8)) u_rom (
    .clk_i   (clk_ph1),
    .we_i    (rom_we),
    .addr_i  (rom_addr),
    .wdata_i (ld_data),
    .rdata_o (rom_rdata)
  );

  // Loader FSM: accept bytes in LOAD, release the CPU in RUN, reload restarts at offset 0.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_ptr   = ld_reload ? '0 : ptr_q;
    rom_we   = 1'b0;
    ld_ready = 1'b0;
    cpu_hold = 1'b0;
    case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        if (ld_reload) ptr_d = '0;
        if (ld_valid) begin
          rom_we = 1'b1;
          ptr_d  = wr_ptr + 1'b1;
          if (ld_last || wr_ptr == PTR_MAX) begin
            state_d = RUN;
            ptr_d   = '0;
          end
        end
      end
      RUN: begin
        if (ld_reload) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Read path: both memories have registered outputs, so the edge that samples the
  // address only records which source Data_bus should show; everything else is held in hold_q.
  always_comb begin
    case (src_q)
      SRC_RAM: Data_bus = ram_rdata;
      SRC_ROM: Data_bus = rom_rdata;
      default: Data_bus = hold_q;
    endcase
    latch_d = (src_q != SRC_HOLD) ? Data_bus : latch_q;
    src_d   = SRC_HOLD;
    hold_d  = Data_bus;
    if (run && rw) begin
      if (ram_hit)      src_d  = SRC_RAM;
      else if (prg_hit) src_d  = SRC_ROM;
      else              hold_d = OPEN_BUS ? latch_d : '0;
    end
  end

  // State, pointer and bus-source registers.
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      src_q   <= SRC_HOLD;
      hold_q  <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      hold_q  <= hold_d;
      latch_q <= latch_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: one open-bus 32 KB instance and one
// zero-fill 16 KB instance driven by the same stimulus.
module tb_cpu_bus_responder;
  import nes_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  ld_data;
  logic        ld_valid, ld_last, ld_reload;
  logic [7:0]  db1, db0;
  logic        rdy1, rdy0, hold1, hold0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_bus_responder #(.RAM_AW(11), .PRG_AW(15), .OPEN_BUS(1'b1)) dut (
    .clk_ph1(clk), .rst(rst), .Addr_bus(addr), .rw(rw), .Data_wr(wdata),
    .Data_bus(db1), .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(rdy1), .ld_reload(ld_reload), .cpu_hold(hold1)
  );

  cpu_bus_responder #(.RAM_AW(11), .PRG_AW(14), .OPEN_BUS(1'b0)) dut0 (
    .clk_ph1(clk), .rst(rst), .Addr_bus(addr), .rw(rw), .Data_wr(wdata),
    .Data_bus(db0), .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(rdy0), .ld_reload(ld_reload), .cpu_hold(hold0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rw = 1'b0; addr = 16'h2000; wdata = 8'h00;
  endtask

  task automatic rd(input logic [15:0] a);
    rw = 1'b1; addr = a;
    tick();
    idle();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    rw = 1'b0; addr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic ldb(input logic [7:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int unsigned i);
    logic [15:0] v;
    v = 16'(i);
    return v[7:0] + {1'b0, v[14:8]};
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; idle(); ld_data = 8'h00; ld_valid = 1'b0; ld_last = 1'b0; ld_reload = 1'b0;
    tick(); tick();
    chk("reset Data_bus", db1, 8'h00);
    chk("reset ld_ready", {7'd0, rdy1}, 8'h01);
    chk("reset cpu_hold", {7'd0, hold1}, 8'h01);
    rst = 1'b1;
    tick();

    // 1: four-byte image, ld_last on the final byte.
    ldb(ADC_IMM, 1'b0);
    ldb(8'h64, 1'b0);
    ldb(SEC, 1'b0);
    chk("ld_ready before last", {7'd0, rdy1}, 8'h01);
    ldb(SBC_IMM, 1'b1);
    chk("ld_ready after last", {7'd0, rdy1}, 8'h00);
    chk("cpu_hold after last", {7'd0, hold1}, 8'h00);
    chk("cpu_hold after last dut0", {7'd0, hold0}, 8'h00);
    rd(16'h8002);
    chk("read 8002", db1, 8'h38);
    chk("read 8002 dut0", db0, 8'h38);

    // 2: RAM write and mirrors.
    wr(16'h0001, 8'hA5);
    chk("write holds Data_bus", db1, 8'h38);
    rd(16'h0801); chk("read 0801", db1, 8'hA5);
    rd(16'h1001); chk("read 1001", db1, 8'hA5);
    rd(16'h1801); chk("read 1801", db0, 8'hA5);

    // 3: open bus after a ROM read.
    rd(16'h8000); chk("read 8000", db1, 8'h69);
    rd(16'h4016);
    chk("open bus 4016", db1, 8'h69);
    chk("zero bus 4016", db0, 8'h00);
    rd(16'h0001); rd(16'h2000);
    chk("open bus after RAM read", db1, 8'hA5);
    rd(16'h8000);

    // 4: dropped ROM write.
    wr(16'h8000, 8'h55);
    rd(16'h4000); chk("latch after dropped write", db1, 8'h69);
    rd(16'h8000); chk("ROM write dropped", db1, 8'h69);
    rd(16'h4000);
    chk("open bus 4000", db1, 8'h69);
    chk("zero bus 4000", db0, 8'h00);

    // 6: reset mid-load, partial reload, then reload from RUN.
    rst = 1'b0; #1;
    chk("mid-run reset Data_bus", db1, 8'h00);
    chk("mid-run reset cpu_hold", {7'd0, hold1}, 8'h01);
    rst = 1'b1;
    tick();
    ldb(8'h11, 1'b0);
    ldb(8'h22, 1'b0);
    rst = 1'b0; #1;
    chk("mid-load reset ld_ready", {7'd0, rdy1}, 8'h01);
    rst = 1'b1;
    tick();
    ldb(NOP, 1'b1);
    chk("reload done cpu_hold", {7'd0, hold1}, 8'h00);
    rd(16'h8000); chk("reload 8000", db1, 8'hEA);
    rd(16'h8001); chk("retained 8001", db1, 8'h22);
    rd(16'h8002); chk("retained 8002", db1, 8'h38);
    rw = 1'b1; addr = 16'h8001; ld_reload = 1'b1;
    tick();
    ld_reload = 1'b0; idle();
    chk("ld_reload cpu_hold", {7'd0, hold1}, 8'h01);
    chk("ld_reload ld_ready", {7'd0, rdy1}, 8'h01);
    chk("read during reload", db1, 8'h22);
    wr(16'h0001, 8'h77);
    chk("LOAD ignores CPU", db1, 8'h22);

    // 5: full image without ld_last; first byte restarts offset via ld_reload.
    ldb(8'h99, 1'b0);
    for (int unsigned i = 0; i < 32768; i++) begin
      ld_valid = 1'b1; ld_data = pat(i); ld_reload = (i == 0);
      if (i == 16383) chk("dut0 ready before wrap", {7'd0, rdy0}, 8'h01);
      if (i == 32767) chk("dut ready before wrap", {7'd0, rdy1}, 8'h01);
      tick();
      ld_reload = 1'b0;
      if (i == 16383) chk("dut0 auto RUN", {7'd0, rdy0}, 8'h00);
    end
    ld_valid = 1'b0;
    chk("auto RUN ld_ready", {7'd0, rdy1}, 8'h00);
    chk("auto RUN cpu_hold", {7'd0, hold1}, 8'h00);
    rd(16'hFFFC);
    chk("vector FFFC", db1, 8'h7B);
    chk("vector FFFC dut0", db0, 8'h3B);
    rd(16'hFFFD);
    chk("vector FFFD", db1, 8'h7C);
    chk("vector FFFD dut0", db0, 8'h3C);
    rd(16'h8000);
    chk("ROM 8000", db1, 8'h00);
    rd(16'hC000);
    chk("ROM C000", db1, 8'h40);
    chk("mirror C000 dut0", db0, 8'h00);
    rd(16'h8001);
    chk("mirror 8001 dut0", db0, 8'h01);
    rd(16'h0001);
    chk("RAM kept through LOAD", db1, 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
